// File: rtl/decode_stage.sv
// decode_stage: instruction decode with two-entry skid buffer; define ILLEGAL_HALT_EN to halt on illegal opcodes
module decode_stage #(
  parameter int RW = 4,
  parameter int IW = 16,
  localparam int CW = 5 + 4 * RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [IW-1:0] in_ins,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  output logic [CW-1:0] out_ctl,
  output logic          out_illegal,
  input  logic          out_ready,
  output logic          halted
);
  logic [4:0] op;
  logic [2*RW-1:0] f;
  logic [CW-1:0] dec_ctl, main_ctl, skid_ctl;
  logic dec_ill, main_ill, skid_ill, main_v, skid_v, acc, pop, run;
  logic unused_bits;
  assign op = in_ins[IW-1:IW-5];
  assign f = in_ins[2*RW-1:0];
  assign unused_bits = ^in_ins;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign in_ready = !skid_v && run;
  assign out_valid = main_v;
  assign out_ctl = main_ctl;
  assign out_illegal = main_ill;
  // classify the opcode and pack its operand field into the control word
  always_comb begin
    dec_ctl = '0;
    dec_ill = 1'b0;
    case (op)
      5'b00000, 5'b00001, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
      5'b01101, 5'b01110, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b00100:
        dec_ctl = {op, f, {2*RW{1'b0}}};
      5'b10100, 5'b10101, 5'b00110:
        dec_ctl = {op, f[2*RW-1:RW], {2*RW{1'b0}}, f[RW-1:0]};
      5'b10110, 5'b10111, 5'b00101:
        dec_ctl = {op, {2*RW{1'b0}}, f};
      default:
        dec_ill = 1'b1;
    endcase
  end
  // main/skid buffer: skid refills main on pop, new beats land in main when it frees up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_ctl <= '0;
      main_ill <= 1'b0;
      skid_ctl <= '0;
      skid_ill <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_ctl <= '0;
      main_ill <= 1'b0;
    end else if (pop && skid_v) begin
      main_ctl <= skid_ctl;
      main_ill <= skid_ill;
      skid_v <= 1'b0;
    end else if (acc && (!main_v || pop)) begin
      main_v <= 1'b1;
      main_ctl <= dec_ctl;
      main_ill <= dec_ill;
    end else if (acc) begin
      skid_v <= 1'b1;
      skid_ctl <= dec_ctl;
      skid_ill <= dec_ill;
    end else if (pop) begin
      main_v <= 1'b0;
    end
  end
`ifdef ILLEGAL_HALT_EN
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  // enter HALT on an accepted illegal beat, leave only on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else if (flush) state <= RUN;
    else if (acc && dec_ill) state <= HALT;
  end
  assign run = state == RUN;
  assign halted = state == HALT;
`else
  assign run = 1'b1;
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors checked against a queue model of the decode stage
module tb_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [15:0] in_ins = '0;
  logic in_ready, out_valid, out_illegal, halted;
  logic [20:0] out_ctl;
  int total = 0, bad = 0;
  logic [21:0] q[$];
  bit halt_m = 1'b0, acc_m, pop_m;
  logic [21:0] e_m;
`ifdef ILLEGAL_HALT_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ins(in_ins), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ctl(out_ctl), .out_illegal(out_illegal),
    .out_ready(out_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  // expected {ctl, illegal} from the opcode tables, built arithmetically
  function automatic logic [21:0] mdl(input logic [15:0] i);
    int op, fa, fb, c;
    op = int'(i[15:11]);
    fa = int'(i[7:4]);
    fb = int'(i[3:0]);
    if (op inside {0, 1, 8, 9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 4})
      c = op * 65536 + (fa * 16 + fb) * 256;
    else if (op inside {20, 21, 6})
      c = op * 65536 + fa * 4096 + fb;
    else if (op inside {22, 23, 5})
      c = op * 65536 + fa * 16 + fb;
    else
      return 22'h1;
    return {21'(c), 1'b0};
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    halt_m = 1'b0;
  end

  always @(posedge clk) if (rst_n) begin
    acc_m = in_valid && q.size() < 2 && !halt_m;
    pop_m = q.size() > 0 && out_ready;
    if (flush) begin
      q.delete();
      halt_m = 1'b0;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (acc_m) begin
        e_m = mdl(in_ins);
        q.push_back(e_m);
        if (HEN && e_m[0]) halt_m = 1'b1;
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2 && !halt_m));
    chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("m_halted", 32'(halted), 32'(halt_m));
    if (q.size() > 0) begin
      chk("m_out_ctl", 32'(out_ctl), 32'(q[0][21:1]));
      chk("m_out_illegal", 32'(out_illegal), 32'(q[0][0]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_ctl", 32'(out_ctl), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    in_valid = 1'b1; in_ins = 16'h4312; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("r_valid", 32'(out_valid), 1);
    chk("r_ctl", 32'(out_ctl), 32'h081200);
    chk("r_ill", 32'(out_illegal), 0);
    in_valid = 1'b1; in_ins = 16'hA0A5;
    cyc();
    chk("ri_ctl", 32'(out_ctl), 32'h14A005);
    in_ins = 16'h2833;
    cyc();
    chk("i_ctl", 32'(out_ctl), 32'h050033);
    in_valid = 1'b0;
    cyc();
    chk("drain_valid", 32'(out_valid), 0);
    out_ready = 1'b0; in_valid = 1'b1; in_ins = 16'h4312;
    cyc();
    chk("bp_ready1", 32'(in_ready), 1);
    in_ins = 16'hA0A5;
    cyc();
    chk("bp_ready2", 32'(in_ready), 0);
    in_ins = 16'h2833;
    cyc();
    chk("bp_ready3", 32'(in_ready), 0);
    chk("bp_stable", 32'(out_ctl), 32'h081200);
    out_ready = 1'b1;
    cyc();
    chk("bp_second", 32'(out_ctl), 32'h14A005);
    chk("bp_ready4", 32'(in_ready), 1);
    cyc();
    chk("bp_third", 32'(out_ctl), 32'h050033);
    in_valid = 1'b0;
    cyc();
    chk("bp_empty", 32'(out_valid), 0);
    in_valid = 1'b1; in_ins = 16'hF800;
    cyc();
    in_valid = 1'b0;
    chk("ill_ctl", 32'(out_ctl), 0);
    chk("ill_flag", 32'(out_illegal), 1);
`ifdef ILLEGAL_HALT_EN
    chk("ill_halted", 32'(halted), 1);
    chk("ill_ready", 32'(in_ready), 0);
    in_valid = 1'b1; in_ins = 16'h4312;
    cyc();
    chk("halt_refuse", 32'(out_valid), 0);
    chk("halt_hold", 32'(halted), 1);
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("unhalt", 32'(halted), 0);
    chk("unhalt_ready", 32'(in_ready), 1);
`else
    in_valid = 1'b1; in_ins = 16'h4312;
    cyc();
    in_valid = 1'b0;
    chk("post_ill_ctl", 32'(out_ctl), 32'h081200);
    chk("post_ill_flag", 32'(out_illegal), 0);
`endif
    cyc();
    out_ready = 1'b0; in_valid = 1'b1; in_ins = 16'h4312;
    cyc();
    in_ins = 16'hA0A5;
    cyc();
    in_ins = 16'h2833; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    cyc();
    chk("flush_gone", 32'(out_valid), 0);
    in_valid = 1'b1; in_ins = 16'h4312; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop", 32'(out_valid), 0);
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_ins = {5'(i), 3'b101, 8'(i * 37 + 11)};
      out_ready = (i % 3) != 0;
      flush = halted;
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; flush = halted;
    cyc();
    flush = 1'b0;
    repeat (3) cyc();
    in_valid = 1'b1; in_ins = 16'hA0A5; out_ready = 1'b0;
    repeat (2) cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ctl", 32'(out_ctl), 0);
    chk("arst_halted", 32'(halted), 0);
    cyc();
    rst_n = 1'b1; in_valid = 1'b0;
    cyc();
    chk("arst_ready", 32'(in_ready), 1);
    chk("arst_empty", 32'(out_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
